qspi_tx_shifter: RTL and testbench

//  Parametrised transmit shifter for the QSPI master. Serialises a DW-bit word onto
//  1, 2 or 4 IO lanes, selectable per transfer, LSB- or MSB-first.

---
 rtl/qspi_tx_shifter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_qspi_tx_shifter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_tx_shifter.sv
// -----------------------------------------------------------------------------
// qspi_tx_shifter
//
// Transmit shifter for the QSPI master. A DW-bit word is captured on start_i
// and serialised onto 1, 2 or 4 IO lanes, one lane-group per step_i strobe
// from the SCK generator, either LSB-first or MSB-first. The word, lane count,
// bit order and (clamped) length are all captured at start, so the inputs are
// free to change while a transfer is in flight.
//
// Ports
//   clk_i        in   1   system clock
//   rst_ni       in   1   asynchronous active-low reset
//   start_i      in   1   begin transfer (only honoured in IDLE)
//   abort_i      in   1   synchronous abort, back to IDLE without done
//   step_i       in   1   shift strobe, advance one lane-group
//   mode_i       in   2   00 single, 01 dual, 10 quad, 11 reserved (single)
//   lsb_first_i  in   1   1: bit 0 first, 0: bit len-1 first
//   len_i        in   CW  transfer length in bits, values above DW clamp to DW
//   din_i        in   DW  transmit word, bits [len-1:0] valid
//   sdo_o        out  4   lane data IO3..IO0
//   oe_o         out  4   lane output enables
//   busy_o       out  1   transfer in progress
//   done_o       out  1   one-cycle completion pulse
//   bit_index_o  out  CW  number of bits already shifted out
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module qspi_tx_shifter #(
    parameter int DW = 64,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          step_i,
    input  logic [1:0]    mode_i,
    input  logic          lsb_first_i,
    input  logic [CW-1:0] len_i,
    input  logic [DW-1:0] din_i,
    output logic [3:0]    sdo_o,
    output logic [3:0]    oe_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] bit_index_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // One extra bit so that index + lanes can never wrap in the compare.
    typedef logic [CW:0] ext_t;

    localparam ext_t DW_EXT = ext_t'(DW);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Number of active lanes for a mode code; the reserved code behaves as single.
    function automatic logic [2:0] mode_lanes(input logic [1:0] mode);
        logic [2:0] lanes;
        case (mode)
            2'b01:   lanes = 3'd2;
            2'b10:   lanes = 3'd4;
            default: lanes = 3'd1;
        endcase
        return lanes;
    endfunction

    // Output-enable pattern: the low 'lanes' lanes are driven.
    function automatic logic [3:0] lane_oe(input logic [2:0] lanes);
        logic [3:0] oe;
        case (lanes)
            3'd2:    oe = 4'b0011;
            3'd4:    oe = 4'b1111;
            default: oe = 4'b0001;
        endcase
        return oe;
    endfunction

    // Lengths beyond the word width are treated as a full word.
    function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] len);
        logic [CW-1:0] res;
        if ({1'b0, len} > DW_EXT) begin
            res = DW_EXT[CW-1:0];
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Reorder the word so that transmit order is always ascending bit index.
    // For MSB-first the word is mirrored across the full width and then shifted
    // down by (DW - len), which lands din[len-1] at bit 0 and zero-fills above len.
    function automatic logic [DW-1:0] order_bits(input logic [DW-1:0] din,
                                                 input logic [CW-1:0] len,
                                                 input logic          lsb);
        logic [DW-1:0] rev;
        logic [DW-1:0] res;
        ext_t          sh;
        for (int i = 0; i < DW; i++) begin
            rev[i] = din[DW-1-i];
        end
        sh = DW_EXT - {1'b0, len};
        if (lsb) begin
            res = din;
        end else begin
            res = rev >> sh;
        end
        return res;
    endfunction

    // Lane-group starting at transmit position idx. Positions at or beyond len
    // drive 0. LSB-first puts the earliest bit on IO0, MSB-first on IO(lanes-1).
    function automatic logic [3:0] lane_group(input logic [DW-1:0] data,
                                              input logic [CW-1:0] len,
                                              input ext_t          idx,
                                              input logic [2:0]    lanes,
                                              input logic          lsb);
        logic [3:0]    grp;
        logic [DW-1:0] shifted;
        ext_t          pos;
        logic [2:0]    k_w;
        logic [2:0]    lane;
        logic          bit_v;
        grp = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            k_w     = 3'(k);
            pos     = idx + ext_t'(k);
            shifted = data >> pos;
            if ((k_w < lanes) && (pos < {1'b0, len})) begin
                bit_v = shifted[0];
            end else begin
                bit_v = 1'b0;
            end
            if (lsb) begin
                lane = k_w;
            end else begin
                lane = lanes - 3'd1 - k_w;
            end
            grp = grp | (4'(bit_v) << lane);
        end
        return grp;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e        state_r,   state_s;
    logic [DW-1:0] data_r,    data_s;
    logic [CW-1:0] len_r,     len_s;
    logic [2:0]    lanes_r,   lanes_s;
    logic          lsb_r,     lsb_s;
    logic [CW-1:0] idx_r,     idx_s;
    logic [3:0]    sdo_r,     sdo_s;
    logic [3:0]    oe_r,      oe_s;
    logic          busy_r,    busy_s;
    logic          done_r,    done_s;

    // Capture-side values derived from the live inputs.
    logic [CW-1:0] cap_len_s;
    logic [2:0]    cap_lanes_s;
    logic [DW-1:0] cap_data_s;
    logic          accept_s;

    // Advance-side values derived from the captured transfer.
    ext_t          idx_step_s;
    logic          last_s;

    assign cap_len_s   = clamp_len(len_i);
    assign cap_lanes_s = mode_lanes(mode_i);
    assign cap_data_s  = order_bits(din_i, cap_len_s, lsb_first_i);
    // abort_i in IDLE blocks a simultaneous start; zero length is ignored.
    assign accept_s    = start_i && !abort_i && (len_i != {CW{1'b0}});

    assign idx_step_s  = {1'b0, idx_r} + ext_t'(lanes_r);
    assign last_s      = (idx_step_s >= {1'b0, len_r});

    // Next-state and next-output logic; every output is computed one cycle ahead.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        len_s   = len_r;
        lanes_s = lanes_r;
        lsb_s   = lsb_r;
        idx_s   = idx_r;
        sdo_s   = sdo_r;
        oe_s    = oe_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SHIFT;
                    data_s  = cap_data_s;
                    len_s   = cap_len_s;
                    lanes_s = cap_lanes_s;
                    lsb_s   = lsb_first_i;
                    idx_s   = {CW{1'b0}};
                    sdo_s   = lane_group(cap_data_s, cap_len_s, {(CW+1){1'b0}},
                                         cap_lanes_s, lsb_first_i);
                    oe_s    = lane_oe(cap_lanes_s);
                    busy_s  = 1'b1;
                end else begin
                    idx_s   = {CW{1'b0}};
                    sdo_s   = 4'b0000;
                    oe_s    = 4'b0000;
                    busy_s  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (abort_i) begin
                    // Abort wins over a coincident step and never raises done.
                    state_s = ST_IDLE;
                    idx_s   = {CW{1'b0}};
                    sdo_s   = 4'b0000;
                    oe_s    = 4'b0000;
                    busy_s  = 1'b0;
                end else if (step_i) begin
                    if (last_s) begin
                        state_s = ST_IDLE;
                        idx_s   = {CW{1'b0}};
                        sdo_s   = 4'b0000;
                        oe_s    = 4'b0000;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        idx_s   = idx_step_s[CW-1:0];
                        sdo_s   = lane_group(data_r, len_r, idx_step_s, lanes_r, lsb_r);
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {CW{1'b0}};
                sdo_s   = 4'b0000;
                oe_s    = 4'b0000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, captured transfer and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            data_r  <= {DW{1'b0}};
            len_r   <= {CW{1'b0}};
            lanes_r <= 3'd1;
            lsb_r   <= 1'b0;
            idx_r   <= {CW{1'b0}};
            sdo_r   <= 4'b0000;
            oe_r    <= 4'b0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            len_r   <= len_s;
            lanes_r <= lanes_s;
            lsb_r   <= lsb_s;
            idx_r   <= idx_s;
            sdo_r   <= sdo_s;
            oe_r    <= oe_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign sdo_o       = sdo_r;
    assign oe_o        = oe_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign bit_index_o = idx_r;

endmodule

// File: tb/tb_qspi_tx_shifter.sv
// -----------------------------------------------------------------------------
// tb_qspi_tx_shifter
//
// Directed and randomised transfers checked against a bit-level reference
// model computed from the lane-mapping rules (reorder, group, place on lanes).
// -----------------------------------------------------------------------------
module tb_qspi_tx_shifter;

    localparam int DW = 64;
    localparam int CW = $clog2(DW + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          abort_i;
    logic          step_i;
    logic [1:0]    mode_i;
    logic          lsb_first_i;
    logic [CW-1:0] len_i;
    logic [DW-1:0] din_i;
    logic [3:0]    sdo_o;
    logic [3:0]    oe_o;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] bit_index_o;

    int errors = 0;
    int checks = 0;

    qspi_tx_shifter #(.DW(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .step_i      (step_i),
        .mode_i      (mode_i),
        .lsb_first_i (lsb_first_i),
        .len_i       (len_i),
        .din_i       (din_i),
        .sdo_o       (sdo_o),
        .oe_o        (oe_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bit_index_o (bit_index_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Reference: transmit order position p carries din[p] (LSB-first) or
    // din[lc-1-p] (MSB-first); group g covers positions g*nl .. g*nl+nl-1.
    function automatic logic [3:0] exp_group(input logic [63:0] din, input int lc,
                                             input int nl, input logic lsb, input int g);
        logic [3:0] r;
        int         pos;
        int         src;
        logic       b;
        r = 4'd0;
        for (int k = 0; k < nl; k++) begin
            pos = g * nl + k;
            if (pos >= lc) begin
                b = 1'b0;
            end else begin
                src = lsb ? pos : (lc - 1 - pos);
                b   = din[src];
            end
            if (lsb) r[k] = b;
            else     r[nl-1-k] = b;
        end
        return r;
    endfunction

    // Full transfer from the current (IDLE or done) cycle; returns in the done cycle.
    task automatic run_xfer(input logic [63:0] din, input int len, input logic [1:0] mode,
                            input logic lsb, input int gap, input logic poke);
        int         lc;
        int         nl;
        int         ng;
        logic [3:0] eoe;
        lc  = (len > DW) ? DW : len;
        nl  = (mode == 2'b01) ? 2 : ((mode == 2'b10) ? 4 : 1);
        ng  = (lc + nl - 1) / nl;
        eoe = 4'((1 << nl) - 1);
        din_i = din; len_i = CW'(len); mode_i = mode; lsb_first_i = lsb; start_i = 1'b1;
        tick;
        start_i = 1'b0;
        din_i   = {$urandom, $urandom};
        mode_i  = 2'($urandom_range(0, 3));
        lsb_first_i = ~lsb;
        check("done_after_start", done_o, 1'b0);
        if (lc == 0) begin
            check("len0_busy", busy_o, 1'b0);
            check("len0_oe", oe_o, 4'd0);
            return;
        end
        check("start_busy", busy_o, 1'b1);
        check("start_oe", oe_o, eoe);
        check("g0_sdo", sdo_o, exp_group(din, lc, nl, lsb, 0));
        check("g0_idx", bit_index_o, 0);
        for (int g = 0; g < ng; g++) begin
            for (int w = 0; w < gap; w++) begin
                start_i = poke;
                din_i   = {$urandom, $urandom};
                tick;
                start_i = 1'b0;
                check("hold_sdo", sdo_o, exp_group(din, lc, nl, lsb, g));
                check("hold_idx", bit_index_o, g * nl);
                check("hold_busy", busy_o, 1'b1);
            end
            step_i  = 1'b1;
            start_i = poke;
            tick;
            step_i  = 1'b0;
            start_i = 1'b0;
            if (g < ng - 1) begin
                check("step_sdo", sdo_o, exp_group(din, lc, nl, lsb, g + 1));
                check("step_idx", bit_index_o, (g + 1) * nl);
                check("step_oe", oe_o, eoe);
                check("step_done", done_o, 1'b0);
            end else begin
                check("end_done", done_o, 1'b1);
                check("end_busy", busy_o, 1'b0);
                check("end_sdo", sdo_o, 4'd0);
                check("end_oe", oe_o, 4'd0);
                check("end_idx", bit_index_o, 0);
            end
        end
    endtask

    logic [3:0] t4_exp [4];

    initial begin
        t4_exp = '{4'h1, 4'h2, 4'h3, 4'h4};
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; step_i = 1'b0;
        mode_i = 2'b00; lsb_first_i = 1'b0; len_i = '0; din_i = '0;
        #12;
        check("rst_sdo", sdo_o, 4'd0);
        check("rst_oe", oe_o, 4'd0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_idx", bit_index_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick;

        // Quad LSB 0xA5: groups 0x5 then 0xA.
        din_i = 64'hA5; len_i = CW'(8); mode_i = 2'b10; lsb_first_i = 1'b1; start_i = 1'b1;
        tick;
        start_i = 1'b0;
        check("t1_g0", sdo_o, 4'h5);
        check("t1_oe", oe_o, 4'hF);
        step_i = 1'b1; tick;
        check("t1_g1", sdo_o, 4'hA);
        check("t1_idx", bit_index_o, 4);
        tick; step_i = 1'b0;
        check("t1_done", done_o, 1'b1);
        tick;
        check("t1_done_pulse", done_o, 1'b0);

        // Single MSB 0x81, dual LSB 0x1B len 5 (partial last group).
        run_xfer(64'h81, 8, 2'b00, 1'b0, 0, 1'b0);
        run_xfer(64'h1B, 5, 2'b01, 1'b1, 1, 1'b0);

        // Quad MSB 0x1234 with 2-cycle gaps, abort after the 2nd step.
        din_i = 64'h1234; len_i = CW'(16); mode_i = 2'b10; lsb_first_i = 1'b0; start_i = 1'b1;
        tick;
        start_i = 1'b0;
        check("t4_g0", sdo_o, t4_exp[0]);
        for (int s = 0; s < 2; s++) begin
            tick; check("t4_hold_a", sdo_o, t4_exp[s]);
            tick; check("t4_hold_b", sdo_o, t4_exp[s]);
            step_i = 1'b1; tick; step_i = 1'b0;
            check("t4_step", sdo_o, t4_exp[s+1]);
        end
        abort_i = 1'b1; tick; abort_i = 1'b0;
        check("t4_abort_busy", busy_o, 1'b0);
        check("t4_abort_sdo", sdo_o, 4'd0);
        check("t4_abort_oe", oe_o, 4'd0);
        check("t4_abort_idx", bit_index_o, 0);
        check("t4_abort_done", done_o, 1'b0);
        tick;
        check("t4_abort_nodone", done_o, 1'b0);

        // Abort in IDLE blocks start; abort beats a coincident step.
        din_i = 64'hFF; len_i = CW'(8); mode_i = 2'b00; start_i = 1'b1; abort_i = 1'b1;
        tick;
        start_i = 1'b0; abort_i = 1'b0;
        check("idle_abort_busy", busy_o, 1'b0);
        start_i = 1'b1; tick; start_i = 1'b0;
        check("ab_step_busy0", busy_o, 1'b1);
        step_i = 1'b1; abort_i = 1'b1; tick; step_i = 1'b0; abort_i = 1'b0;
        check("ab_step_busy", busy_o, 1'b0);
        check("ab_step_done", done_o, 1'b0);
        tick;
        check("ab_step_nodone", done_o, 1'b0);

        // len 0 ignored, start during busy ignored, len 70 clamps, back-to-back.
        run_xfer({$urandom, $urandom}, 0, 2'b10, 1'b1, 0, 1'b0);
        run_xfer({$urandom, $urandom}, 70, 2'b10, 1'b1, 0, 1'b1);
        run_xfer({$urandom, $urandom}, 70, 2'b10, 1'b0, 1, 1'b1);
        run_xfer({$urandom, $urandom}, 7, 2'b11, 1'b0, 0, 1'b1);

        // Asynchronous reset mid quad transfer.
        tick;
        din_i = {$urandom, $urandom}; len_i = CW'(32); mode_i = 2'b10; start_i = 1'b1;
        tick;
        start_i = 1'b0;
        step_i = 1'b1; tick; step_i = 1'b0;
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_sdo", sdo_o, 4'd0);
        check("arst_oe", oe_o, 4'd0);
        check("arst_busy", busy_o, 1'b0);
        check("arst_idx", bit_index_o, 0);
        check("arst_done", done_o, 1'b0);
        #1;
        rst_ni = 1'b1;
        tick;
        check("arst_after_done", done_o, 1'b0);
        check("arst_after_busy", busy_o, 1'b0);
        tick;
        check("arst_after_done2", done_o, 1'b0);

        // Randomised transfers, mostly back-to-back, some with idle gaps.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick;
                check("gap_done", done_o, 1'b0);
            end
            run_xfer({$urandom, $urandom}, $urandom_range(0, DW + 6),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        tick;
        check("final_done", done_o, 1'b0);
        check("final_busy", busy_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
